frame_buffer_ctrl: RTL

//  Consumes the pixel stream (draw_x/draw_y/draw_color) emitted by the drawing engine.

---
 rtl/fb_pkg.sv | 16 +
 rtl/frame_buffer_ctrl_if.sv | 34 +++
 rtl/fb_addr_gen.sv | 32 +++
 rtl/frame_buffer_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered frame memory controller.
package fb_pkg;

  localparam int FB_W      = 640;
  localparam int FB_H      = 480;
  localparam int FB_ADDR_W = 20;

  typedef logic [7:0] color_t;
  typedef logic [9:0] coord_t;

  typedef enum logic {
    DRAW,
    WAIT_VBLANK
  } swap_state_t;

endpackage

// File: rtl/frame_buffer_ctrl_if.sv
// Bundle of drawing-engine, VGA scan-out and external memory signals around the controller.
interface frame_buffer_ctrl_if;
  import fb_pkg::*;

  logic                 draw_valid;
  coord_t               draw_x;
  coord_t               draw_y;
  color_t               draw_color;
  logic                 frame_done;
  logic                 wr_en;
  logic                 buffer_using;
  logic                 vga_vs;
  logic                 vga_blank;
  coord_t               vga_x;
  coord_t               vga_y;
  color_t               pixel_color;
  logic [FB_ADDR_W-1:0] mem_addr;
  logic                 mem_we;
  color_t               mem_wdata;
  color_t               mem_rdata;

  modport slave (
    input  draw_valid, draw_x, draw_y, draw_color, frame_done,
    input  vga_vs, vga_blank, vga_x, vga_y, mem_rdata,
    output wr_en, buffer_using, pixel_color, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output draw_valid, draw_x, draw_y, draw_color, frame_done,
    output vga_vs, vga_blank, vga_x, vga_y, mem_rdata,
    input  wr_en, buffer_using, pixel_color, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Maps a pixel coordinate and bank bit to a linear frame-memory address {bank, y*W+x}.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int W      = FB_W,
  parameter int H      = FB_H,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              bank_i,
  input  coord_t            x_i,
  input  coord_t            y_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              in_range_o
);

  localparam int OFF_W = ADDR_W - 1;

  logic [OFF_W-1:0] row_base;

  // 640 = 512 + 128, so the row base needs only two shifted adds
  generate
    if (W == 640) begin : g_shift_add
      assign row_base = (OFF_W'(y_i) << 9) + (OFF_W'(y_i) << 7);
    end else begin : g_mult
      assign row_base = OFF_W'(y_i) * OFF_W'(W);
    end
  endgenerate

  assign addr_o     = {bank_i, row_base + OFF_W'(x_i)};
  assign in_range_o = (int'(x_i) < W) && (int'(y_i) < H);

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered frame memory controller: alternates scan-out reads of the front bank
// with engine writes to the back bank, and swaps banks at the vblank after a finished frame.
module frame_buffer_ctrl
  import fb_pkg::*;
#(
  parameter int W = FB_W,
  parameter int H = FB_H
) (
  input  logic               clk,
  input  logic               rst,
  frame_buffer_ctrl_if.slave fb_io
);

  logic                 slot_q;
  logic                 vs_q;
  logic                 bank_q, bank_d;
  logic                 vga_blank_q;
  color_t               pixel_q;
  swap_state_t          state_q, state_d;

  logic [FB_ADDR_W-1:0] wr_addr, rd_addr;
  logic                 wr_in_range, rd_in_range;
  logic                 vs_fall;
  logic                 swap_pending;
  logic                 wr_en;

  fb_addr_gen #(.W(W), .H(H), .ADDR_W(FB_ADDR_W)) u_wr_addr (
    .bank_i     (bank_q),
    .x_i        (fb_io.draw_x),
    .y_i        (fb_io.draw_y),
    .addr_o     (wr_addr),
    .in_range_o (wr_in_range)
  );

  fb_addr_gen #(.W(W), .H(H), .ADDR_W(FB_ADDR_W)) u_rd_addr (
    .bank_i     (~bank_q),
    .x_i        (fb_io.vga_x),
    .y_i        (fb_io.vga_y),
    .addr_o     (rd_addr),
    .in_range_o (rd_in_range)
  );

  assign vs_fall      = vs_q & ~fb_io.vga_vs;
  assign swap_pending = (state_q == WAIT_VBLANK);
  assign wr_en        = slot_q & ~swap_pending & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DRAW;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
    end
  end

  // A frame_done that coincides with the vsync edge swaps immediately instead of waiting
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    case (state_q)
      DRAW: begin
        if (fb_io.frame_done) begin
          if (vs_fall) begin
            bank_d = ~bank_q;
          end else begin
            state_d = WAIT_VBLANK;
          end
        end
      end
      WAIT_VBLANK: begin
        if (vs_fall) begin
          bank_d  = ~bank_q;
          state_d = DRAW;
        end
      end
      default: state_d = DRAW;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q      <= 1'b0;
      vs_q        <= 1'b0;
      vga_blank_q <= 1'b0;
      pixel_q     <= '0;
    end else begin
      slot_q <= ~slot_q;
      vs_q   <= fb_io.vga_vs;
      // Blank flag is carried alongside the read so it lines up with mem_rdata
      if (!slot_q) begin
        vga_blank_q <= fb_io.vga_blank & rd_in_range;
      end else begin
        pixel_q <= vga_blank_q ? fb_io.mem_rdata : '0;
      end
    end
  end

  always_comb begin
    fb_io.mem_addr  = '0;
    fb_io.mem_we    = 1'b0;
    fb_io.mem_wdata = '0;
    if (!rst) begin
      if (slot_q) begin
        if (fb_io.draw_valid && wr_en && wr_in_range) begin
          fb_io.mem_addr  = wr_addr;
          fb_io.mem_we    = 1'b1;
          fb_io.mem_wdata = fb_io.draw_color;
        end
      end else begin
        fb_io.mem_addr = rd_addr;
      end
    end
  end

  assign fb_io.wr_en        = wr_en;
  assign fb_io.buffer_using = bank_q;
  assign fb_io.pixel_color  = pixel_q;

endmodule
